// File: rtl/riscv_pkg.sv
// Shared core definitions: machine width, canonical NOP, reset vector and the
// {instruction, pc} record that moves from fetch into decode.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] INSTR_BYTES      = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

    // Sequential fetch address; wraps modulo 2^XLEN.
    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
        return pc + INSTR_BYTES;
    endfunction

endpackage

// File: rtl/if_stage_fetch_fifo.sv
// Small circular buffer holding fetched {instruction, pc} records.
// Flush empties it in one cycle; storage itself is never reset.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));
    assign do_pop    = pop && !empty;
    // A push into a full buffer is only accepted when the head leaves in the same cycle.
    assign do_push   = push && (!full || do_pop);
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: owns the PC, issues credit-limited in-order fetches and
// hands buffered {instruction, pc} to decode; EX redirects flush stale work.
module if_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [31:0] if_instruction,
    output logic [31:0] if_pc
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rsp_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   outstanding_nxt;
    logic [CW-1:0]   discard;
    logic [CW-1:0]   fifo_count;
    logic [CW:0]     credits_used;

    logic            req_fire;
    logic            rsp_drop;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_empty;
    logic            fifo_full;

    fetch_entry_t    push_entry;
    fetch_entry_t    head_entry;

    // Responses still owed to discard belong to pre-redirect requests, so they
    // do not occupy future buffer space; discard never exceeds outstanding.
    assign credits_used   = {1'b0, outstanding} + {1'b0, fifo_count} - {1'b0, discard};
    assign imem_req_valid = reset && !redirect_valid && (credits_used < (CW+1)'(FIFO_DEPTH));
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_drop        = redirect_valid || (discard != '0);
    assign fifo_push       = imem_rsp_valid && !rsp_drop;
    assign outstanding_nxt = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);

    assign push_entry = '{instr: imem_rsp_data, pc: rsp_pc};

    assign if_valid       = !fifo_empty && !redirect_valid;
    assign fifo_pop       = if_valid && id_ready;
    assign if_instruction = if_valid ? head_entry.instr : NOP_INSTR;
    assign if_pc          = if_valid ? head_entry.pc    : '0;

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fetch_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .head_data (head_entry),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // rsp_pc is the PC of the next response that will be kept: after a redirect
    // every in-flight response is discarded, so it restarts at the target.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc          <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            if (redirect_valid) begin
                pc      <= word_align(redirect_pc);
                rsp_pc  <= word_align(redirect_pc);
                discard <= outstanding_nxt;
            end else begin
                if (req_fire) pc <= next_pc(pc);
                if (imem_rsp_valid && (discard != '0)) discard <= discard - 1'b1;
                if (fifo_push) rsp_pc <= next_pc(rsp_pc);
            end
        end
    end

    rsp_fits_fifo: assert property (@(posedge clk) disable iff (!reset)
        fifo_push |-> (!fifo_full || fifo_pop));

    rsp_has_request: assert property (@(posedge clk) disable iff (!reset)
        imem_rsp_valid |-> (outstanding != '0));

    discard_bounded: assert property (@(posedge clk) disable iff (!reset)
        discard <= outstanding);

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a latency-programmable memory model, an expected
// PC queue filled by the stimulus and a monitor that checks every decode handshake.
module tb_if_stage;
    import riscv_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic        clk            = 1'b0;
    logic        reset          = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = 32'h0;
    logic        id_ready       = 1'b0;
    logic        if_valid;
    logic [31:0] if_instruction;
    logic [31:0] if_pc;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_txn_t;

    mem_txn_t    mem_q[$];
    logic [31:0] exp_pc [256];
    int          exp_wr  = 0;
    int          exp_rd  = 0;
    int          granted = 0;
    int          used    = 0;
    int          lat     = 1;
    int          cyc     = 0;
    int          n_vec   = 0;
    int          n_err   = 0;
    logic        rsp_now = 1'b0;

    if_stage #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .if_valid       (if_valid),
        .if_instruction (if_instruction),
        .if_pc          (if_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic expect_pc(input logic [31:0] pc);
        exp_pc[exp_wr % 256] = pc;
        exp_wr++;
    endtask

    task automatic drain(input string name, input int max_cycles);
        int k;
        k = 0;
        while ((exp_rd != exp_wr || mem_q.size() != 0) && k < max_cycles) begin
            @(negedge clk);
            #4;
            k++;
        end
        n_vec++;
        if (exp_rd != exp_wr || mem_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_drain: %0d expected outputs still pending, %0d fetches in flight",
                     name, exp_wr - exp_rd, mem_q.size());
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic do_redirect(input logic [31:0] target);
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask

    initial begin
        fork
            // Memory model and output monitor: drive at the falling edge,
            // observe handshakes 3 time units later, well before the rising edge.
            forever begin
                @(negedge clk);
                cyc++;
                rsp_now        = reset && (mem_q.size() > 0) && (mem_q[0].due <= cyc);
                imem_rsp_valid = rsp_now;
                imem_rsp_data  = rsp_now ? instr_of(mem_q[0].addr) : 32'h0;
                #1;
                imem_req_ready = (granted > used);
                #2;
                if (!reset) begin
                    mem_q.delete();
                end else begin
                    if (rsp_now) void'(mem_q.pop_front());
                    if (imem_req_valid && imem_req_ready) begin
                        mem_q.push_back('{addr: imem_req_addr, due: cyc + lat});
                        used++;
                    end
                    if (if_valid && id_ready) begin
                        if (exp_rd == exp_wr) begin
                            n_vec++;
                            n_err++;
                            $display("FAIL unexpected_output: got pc %h, no output expected", if_pc);
                        end else begin
                            check("if_pc", if_pc, exp_pc[exp_rd % 256]);
                            check("if_instruction", if_instruction, instr_of(exp_pc[exp_rd % 256]));
                            exp_rd++;
                        end
                    end
                end
            end
        join_none

        // Reset state
        #2;
        check("rst_if_valid", {31'h0, if_valid}, 32'h0);
        check("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
        check("rst_if_instruction", if_instruction, NOP_INSTR);
        check("rst_if_pc", if_pc, 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #3;
        check("first_req_valid", {31'h0, imem_req_valid}, 32'h1);
        check("first_req_addr", imem_req_addr, RESET_PC);

        // 1: streaming, latency 1
        @(negedge clk);
        for (int i = 0; i < 8; i++) expect_pc(32'h0 + 32'(4 * i));
        id_ready = 1'b1;
        granted += 8;
        drain("stream", 100);

        // 2: decode stall fills the buffer, then resumes without gaps
        @(negedge clk);
        id_ready = 1'b0;
        for (int i = 0; i < 6; i++) expect_pc(32'h20 + 32'(4 * i));
        granted += 6;
        repeat (6) @(negedge clk);
        #4;
        check("stall_if_valid", {31'h0, if_valid}, 32'h1);
        check("stall_req_valid", {31'h0, imem_req_valid}, 32'h0);
        check("stall_head_pc", if_pc, 32'h20);
        check("stall_in_flight", 32'(mem_q.size()), 32'h0);
        @(negedge clk);
        id_ready = 1'b1;
        drain("stall", 100);

        // 3: redirect with two fetches in flight at latency 3
        @(negedge clk);
        lat = 3;
        granted += 2;
        begin
            int k;
            k = 0;
            do begin
                @(negedge clk);
                #4;
                k++;
            end while (mem_q.size() != 2 && k < 20);
            check("two_in_flight", 32'(mem_q.size()), 32'h2);
        end
        expect_pc(32'h100);
        expect_pc(32'h104);
        do_redirect(32'h0000_0100);
        granted += 2;
        drain("redirect", 100);

        // 4a: misaligned redirect target is word aligned; request held while not ready
        @(negedge clk);
        lat = 1;
        do_redirect(32'h0000_0103);
        #3;
        check("align_req_valid", {31'h0, imem_req_valid}, 32'h1);
        check("align_req_addr", imem_req_addr, 32'h100);
        @(negedge clk);
        #3;
        check("held_req_addr", imem_req_addr, 32'h100);
        @(negedge clk);
        expect_pc(32'h100);
        granted += 1;
        drain("align", 100);

        // 4b: redirect in the same cycle as a response drops that response
        @(negedge clk);
        lat = 2;
        granted += 1;
        begin
            int k;
            k = 0;
            do begin
                @(negedge clk);
                #2;
                k++;
            end while (!imem_rsp_valid && k < 20);
            check("rsp_seen", {31'h0, imem_rsp_valid}, 32'h1);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0400;
        @(negedge clk);
        redirect_valid = 1'b0;
        expect_pc(32'h400);
        granted += 1;
        drain("rsp_redirect", 100);

        // 5: PC wraps past the top of the address space
        @(negedge clk);
        lat = 1;
        expect_pc(32'hFFFF_FFFC);
        expect_pc(32'h0000_0000);
        do_redirect(32'hFFFF_FFFC);
        granted += 2;
        drain("wrap", 100);

        // 6: asynchronous reset with a full buffer
        @(negedge clk);
        id_ready = 1'b0;
        granted += 2;
        repeat (5) @(negedge clk);
        #3;
        check("full_if_valid", {31'h0, if_valid}, 32'h1);
        check("full_req_valid", {31'h0, imem_req_valid}, 32'h0);
        check("full_head_pc", if_pc, 32'h4);
        #1;
        reset = 1'b0;
        #1;
        check("arst_if_valid", {31'h0, if_valid}, 32'h0);
        check("arst_req_valid", {31'h0, imem_req_valid}, 32'h0);
        check("arst_if_pc", if_pc, 32'h0);
        check("arst_if_instruction", if_instruction, NOP_INSTR);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #3;
        check("rerelease_req_valid", {31'h0, imem_req_valid}, 32'h1);
        check("rerelease_req_addr", imem_req_addr, RESET_PC);
        @(negedge clk);
        expect_pc(32'h0);
        expect_pc(32'h4);
        id_ready = 1'b1;
        granted += 2;
        drain("after_reset", 100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
